// File: rtl/uniq_pkg.sv
// Shared constants and types for the recent-distinct-value history.
package uniq_pkg;

    localparam int unsigned NUM_SLOTS      = 4;
    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef logic [DEFAULT_DATA_W-1:0] slot_t;

endpackage

// File: rtl/uniq_match.sv
// Combinational membership test of a sample against the valid history slots.
module uniq_match
    import uniq_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0]    data_in,
    input  logic [DATA_W-1:0]    slot_1,
    input  logic [DATA_W-1:0]    slot_2,
    input  logic [DATA_W-1:0]    slot_3,
    input  logic [DATA_W-1:0]    slot_4,
    input  logic [NUM_SLOTS-1:0] valid,
    output logic                 hit
);

    // Invalid slots are masked so cleared zeros never count as a match.
    assign hit = (valid[0] && (slot_1 == data_in))
               | (valid[1] && (slot_2 == data_in))
               | (valid[2] && (slot_3 == data_in))
               | (valid[3] && (slot_4 == data_in));

endmodule

// File: rtl/uniq_history.sv
// Four-entry history of the most recent distinct samples, newest in slot 1.
module uniq_history
    import uniq_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2,
    output logic [DATA_W-1:0] data_out_3,
    output logic [DATA_W-1:0] data_out_4,
    output logic              data_out_valid_1,
    output logic              data_out_valid_2,
    output logic              data_out_valid_3,
    output logic              data_out_valid_4
);

    logic [NUM_SLOTS-1:0] valid;
    logic                 hit;

    uniq_match #(
        .DATA_W (DATA_W)
    ) u_match (
        .data_in (data_in),
        .slot_1  (data_out_1),
        .slot_2  (data_out_2),
        .slot_3  (data_out_3),
        .slot_4  (data_out_4),
        .valid   (valid),
        .hit     (hit)
    );

    // A miss shifts every slot one place older; valid stays thermometer-coded.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_out_1 <= '0;
            data_out_2 <= '0;
            data_out_3 <= '0;
            data_out_4 <= '0;
            valid      <= '0;
        end else if (!hit) begin
            data_out_4 <= data_out_3;
            data_out_3 <= data_out_2;
            data_out_2 <= data_out_1;
            data_out_1 <= data_in;
            valid      <= {valid[NUM_SLOTS-2:0], 1'b1};
        end
    end

    assign data_out_valid_1 = valid[0];
    assign data_out_valid_2 = valid[1];
    assign data_out_valid_3 = valid[2];
    assign data_out_valid_4 = valid[3];

endmodule

// File: tb/tb_uniq_history.sv
// Bench for uniq_history: queue-based model checked every cycle plus directed literals.
module tb_uniq_history;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out_1, data_out_2, data_out_3, data_out_4;
    logic       data_out_valid_1, data_out_valid_2, data_out_valid_3, data_out_valid_4;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0] mq[$];

    uniq_history #(
        .DATA_W (8)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .data_in          (data_in),
        .data_out_1       (data_out_1),
        .data_out_2       (data_out_2),
        .data_out_3       (data_out_3),
        .data_out_4       (data_out_4),
        .data_out_valid_1 (data_out_valid_1),
        .data_out_valid_2 (data_out_valid_2),
        .data_out_valid_3 (data_out_valid_3),
        .data_out_valid_4 (data_out_valid_4)
    );

    always #5 clk_in = ~clk_in;

    // Model: list of distinct values, newest first, at most four long.
    always @(negedge rst_n_in) mq.delete();

    always @(posedge clk_in) begin
        if (rst_n_in) begin
            bit found;
            found = 1'b0;
            foreach (mq[i]) if (mq[i] == data_in) found = 1'b1;
            if (!found) begin
                mq.push_front(data_in);
                if (mq.size() > 4) void'(mq.pop_back());
            end
        end
    end

    function automatic logic [35:0] dut_vec();
        return {data_out_1, data_out_2, data_out_3, data_out_4,
                data_out_valid_1, data_out_valid_2, data_out_valid_3, data_out_valid_4};
    endfunction

    function automatic logic [35:0] model_vec();
        logic [35:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < mq.size()) begin
                v[35 - 8*i -: 8] = mq[i];
                v[3 - i]         = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got d=%h,%h,%h,%h v=%b required d=%h,%h,%h,%h v=%b", name,
                     act[35:28], act[27:20], act[19:12], act[11:4], act[3:0],
                     exp[35:28], exp[27:20], exp[19:12], exp[11:4], exp[3:0]);
        end
    endtask

    always @(negedge clk_in) check("model", dut_vec(), model_vec());

    task automatic step(input logic [7:0] v);
        data_in = v;
        @(posedge clk_in);
        #1;
    endtask

    task automatic step_lit(input string name, input logic [7:0] v, input logic [35:0] exp);
        step(v);
        check(name, dut_vec(), exp);
        check({name, "_model"}, model_vec(), exp);
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #2 rst_n_in = 1'b0;
        #1 check("reset_async", dut_vec(), 36'h0);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
    endtask

    initial begin
        #1 rst_n_in = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        check("reset_state", dut_vec(), 36'h0);

        step_lit("fill_01", 8'h01, {8'h01, 8'h00, 8'h00, 8'h00, 4'b1000});
        step_lit("fill_02", 8'h02, {8'h02, 8'h01, 8'h00, 8'h00, 4'b1100});
        step_lit("fill_03", 8'h03, {8'h03, 8'h02, 8'h01, 8'h00, 4'b1110});
        step_lit("fill_04", 8'h04, {8'h04, 8'h03, 8'h02, 8'h01, 4'b1111});
        step_lit("dup_02",  8'h02, {8'h04, 8'h03, 8'h02, 8'h01, 4'b1111});
        step_lit("ev_05",   8'h05, {8'h05, 8'h04, 8'h03, 8'h02, 4'b1111});
        step_lit("ev_06",   8'h06, {8'h06, 8'h05, 8'h04, 8'h03, 4'b1111});
        step_lit("ev_06b",  8'h06, {8'h06, 8'h05, 8'h04, 8'h03, 4'b1111});
        step_lit("ev_04",   8'h04, {8'h06, 8'h05, 8'h04, 8'h03, 4'b1111});
        step_lit("ev_08",   8'h08, {8'h08, 8'h06, 8'h05, 8'h04, 4'b1111});
        step_lit("ev_09",   8'h09, {8'h09, 8'h08, 8'h06, 8'h05, 4'b1111});
        step_lit("oldest_05", 8'h05, {8'h09, 8'h08, 8'h06, 8'h05, 4'b1111});
        step_lit("evicted_03", 8'h03, {8'h03, 8'h09, 8'h08, 8'h06, 4'b1111});

        // Mid-stream reset with all slots full.
        do_reset();
        check("after_reset", dut_vec(), 36'h0);
        step_lit("zero_ins", 8'h00, {8'h00, 8'h00, 8'h00, 8'h00, 4'b1000});
        step_lit("zero_dup", 8'h00, {8'h00, 8'h00, 8'h00, 8'h00, 4'b1000});
        step_lit("zero_1",   8'h01, {8'h01, 8'h00, 8'h00, 8'h00, 4'b1100});
        do_reset();
        step_lit("zero_fresh", 8'h00, {8'h00, 8'h00, 8'h00, 8'h00, 4'b1000});

        do_reset();
        for (int i = 0; i < 10; i++)
            step_lit("const_aa", 8'hAA, {8'hAA, 8'h00, 8'h00, 8'h00, 4'b1000});

        step_lit("ff_ins", 8'hFF, {8'hFF, 8'hAA, 8'h00, 8'h00, 4'b1100});

        // Small value range forces frequent hits and evictions.
        for (int i = 0; i < 300; i++) step(8'($urandom_range(0, 6)));
        for (int i = 0; i < 100; i++) step(8'($urandom));

        do_reset();
        for (int i = 0; i < 50; i++) step(8'($urandom_range(0, 5)));

        @(negedge clk_in);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uniq_history.md
Name: uniq_history

Overview:
- Streaming de-duplication history: samples data_in on every clk_in rising edge.
- Keeps the 4 most recently inserted *distinct* byte values, newest in slot 1 and oldest in slot 4.
- A sample already present in any valid slot is discarded.
- Sits after a byte source to expose a small recent-unique-value window to downstream logic.

Parameters:
- DATA_W, 8, width of data_in and each data_out_N. Slot count is fixed at 4 by the port list.

Ports:
- clk_in  input  1  rising-edge clock.
- rst_n_in  input  1  asynchronous active-low reset.
- data_in  input  DATA_W  sample; captured every clock, no input valid.
- data_out_1  output  DATA_W  slot 1 (newest distinct value).
- data_out_2  output  DATA_W  slot 2.
- data_out_3  output  DATA_W  slot 3.
- data_out_4  output  DATA_W  slot 4 (oldest).
- data_out_valid_1  output  1  slot 1 holds a value.
- data_out_valid_2  output  1  slot 2 holds a value.
- data_out_valid_3  output  1  slot 3 holds a value.
- data_out_valid_4  output  1  slot 4 holds a value.

Behaviour:
- Reset: rst_n_in low clears all data_out_N to 0 and all data_out_valid_N to 0, immediately and independent of the clock.
  - Reset asserted mid-operation discards all history.
  - The first edge after release treats the history as empty.
- Each rising edge with rst_n_in high:
  - hit = OR over N of (data_out_valid_N and data_out_N == data_in).
  - hit=1: all slots and valid bits hold. No reordering; this is not LRU.
  - hit=0 (insert):
    - slot4<=slot3, slot3<=slot2, slot2<=slot1, slot1<=data_in.
    - valid4<=valid3, valid3<=valid2, valid2<=valid1, valid1<=1.
    - The old slot-4 value is evicted.
- Invalid slots never produce a hit, even if their stored data equals data_in. Example: data_in=0 right after reset inserts 0.
- Every value, including 0, is a legal sample.
- Valid bits are thermometer-coded (valid_k=1 implies valid_j=1 for all j<k). They fill 1,2,3,4 over the first 4 distinct samples and then stay all-1 until reset.
- Valid slots are always pairwise distinct.
- Latency: outputs are registers. The effect of the data_in sampled at edge t is visible after edge t. No combinational path from data_in to outputs.
- Repeated identical consecutive samples cause no change after the first insertion.

Decomposition:
- Package uniq_pkg: localparam NUM_SLOTS=4, default DATA_W=8, typedef for a slot value.
- One natural sub-module: uniq_match. It takes data_in, the 4 slot values and the 4 valid bits, and returns a combinational hit flag.
- Top holds the shift registers and reset logic.

Test Plan:
- Reset: drive rst_n_in=0 mid-stream with slots full -> all data_out_N=0 and all valid_N=0 immediately, before the next clock edge.
- Fill: after reset, samples 01,02,03,04 -> slots (04,03,02,01), valid=1111. After the first sample: slot1=01, valid=1000 (valid_1..4).
- Duplicate discard: with slots (04,03,02,01), sample 02 -> unchanged (04,03,02,01).
- Eviction sequence: continue with 05,06,06,04,08,09 -> after each sample:
  - 05: (05,04,03,02)
  - 06: (06,05,04,03)
  - 06: (06,05,04,03)
  - 04: (06,05,04,03)
  - 08: (08,06,05,04)
  - 09: (09,08,06,05)
- Zero and invalid slots: reset, then sample 00 -> slot1=00, valid=1000. Next sample 00 -> no change. Next 00 with fresh reset -> inserted, because the cleared slots are invalid.
- Constant input: hold data_in=AA for 10 clocks after reset -> slot1=AA, valid=1000 throughout, other slots stay 0.
